// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NUM_REQ requesters with exactly one operation in flight.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins priority instead of round-robin.
module alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SEL_W       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [SEL_W-1:0]           alu_sel,
  input  logic [DATA_W-1:0]          alu_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ALU_LATENCY);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
`endif

  logic               any_valid_s;
  logic [ID_W-1:0]    win_idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [DATA_W-1:0]  a_arr_s   [NUM_REQ];
  logic [DATA_W-1:0]  b_arr_s   [NUM_REQ];
  logic [SEL_W-1:0]   sel_arr_s [NUM_REQ];

`ifndef ALU_ARB_FIXED_PRIO_EN
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = (int'(base) + 1 + off) % NUM_REQ;
    return ID_W'(sum);
  endfunction
`endif

  // Unpack the flat requester buses into per-requester arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr_s[i]   = req_a[i*DATA_W +: DATA_W];
      b_arr_s[i]   = req_b[i*DATA_W +: DATA_W];
      sel_arr_s[i] = req_sel[i*SEL_W +: SEL_W];
    end
  end

  // Winner search; scanning from the far end lets the closest candidate overwrite the rest.
  always_comb begin
    any_valid_s = 1'b0;
    win_idx_s   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (req_valid[i]) begin
        any_valid_s = 1'b1;
        win_idx_s   = ID_W'(i);
      end else begin
        win_idx_s   = win_idx_s;
      end
`else
      if (req_valid[rr_idx(last_grant_q, i)]) begin
        any_valid_s = 1'b1;
        win_idx_s   = rr_idx(last_grant_q, i);
      end else begin
        win_idx_s   = win_idx_s;
      end
`endif
    end
  end

  // Grant is offered only while idle and out of reset.
  always_comb begin
    grant_s = '0;
    if ((state_q == S_IDLE) && reset && any_valid_s) begin
      grant_s[win_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Next-state and datapath-update logic for the single in-flight operation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_valid_s) begin
          alu_a_d   = a_arr_s[win_idx_s];
          alu_b_d   = b_arr_s[win_idx_s];
          alu_sel_d = sel_arr_s[win_idx_s];
          rsp_id_d  = win_idx_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = win_idx_s;
`endif
          cnt_d     = '0;
          state_d   = S_WAIT;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rsp_data_d  = alu_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= LAST_INIT;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign req_ready = grant_s;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle plus directed cases.
// Three instances (ALU latency 1, 0, 3) share the request side; the latency-1 one is fully modelled.
module tb_alu_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int LAT = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*SW-1:0] req_sel;
  logic            rsp_ready;

  logic [N-1:0]  req_ready, req_ready0, req_ready3;
  logic [DW-1:0] alu_a, alu_b, alu_out, rsp_data;
  logic [DW-1:0] alu_a0, alu_b0, alu_out0, rsp_data0;
  logic [DW-1:0] alu_a3, alu_b3, alu_out3, rsp_data3;
  logic [SW-1:0] alu_sel, alu_sel0, alu_sel3;
  logic          rsp_valid, rsp_valid0, rsp_valid3, busy, busy0, busy3;
  logic [1:0]    rsp_id, rsp_id0, rsp_id3;

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [SW-1:0] s);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~a;
      4'h6: return a << 1;
      4'h7: return a >> 1;
      default: return a + b + 8'd1;
    endcase
  endfunction

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .ALU_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy));

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .ALU_LATENCY(0)) dut_l0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0), .alu_out(alu_out0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_id(rsp_id0), .rsp_data(rsp_data0),
    .busy(busy0));

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .ALU_LATENCY(3)) dut_l3 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_out(alu_out3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .busy(busy3));

  // ALU models with the matching pipeline depths
  logic [DW-1:0] alu1_q;
  logic [DW-1:0] p3 [3];
  always @(posedge clock) alu1_q <= alu_fn(alu_a, alu_b, alu_sel);
  always @(posedge clock) begin
    p3[0] <= alu_fn(alu_a3, alu_b3, alu_sel3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_out  = alu1_q;
  assign alu_out0 = alu_fn(alu_a0, alu_b0, alu_sel0);
  assign alu_out3 = p3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 operation in the ALU, 2 response pending.
  typedef struct {
    int            phase;
    int            left;
    int            ptr;
    int            id;
    logic [DW-1:0] a, b, data;
    logic [SW-1:0] sel;
  } model_t;

  model_t m, m_next;

  function automatic model_t reset_model();
    model_t r;
    r.phase = 0; r.left = 0; r.ptr = N - 1; r.id = 0;
    r.a = '0; r.b = '0; r.data = '0; r.sel = '0;
    return r;
  endfunction

  function automatic int model_winner(input logic [N-1:0] v, input int ptr);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  initial begin
    m = reset_model();
    m_next = reset_model();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) m = reset_model();
      else m = m_next;
    end
  end

  initial begin
    forever begin
      int w;
      logic [N-1:0] exp_ready;
      model_t nx;
      @(negedge clock);
      w = model_winner(req_valid, m.ptr);
      exp_ready = '0;
      if (reset && m.phase == 0 && w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, m.phase != 0);
      check("rsp_valid", rsp_valid, m.phase == 2);
      check("rsp_id", rsp_id, m.id);
      check("rsp_data", rsp_data, m.data);
      check("alu_a", alu_a, m.a);
      check("alu_b", alu_b, m.b);
      check("alu_sel", alu_sel, m.sel);
      nx = m;
      if (!reset) begin
        nx = reset_model();
      end else if (m.phase == 0 && w >= 0) begin
        nx.phase = 1; nx.left = LAT; nx.ptr = w; nx.id = w;
        nx.a = req_a[w*DW +: DW]; nx.b = req_b[w*DW +: DW]; nx.sel = req_sel[w*SW +: SW];
      end else if (m.phase == 1) begin
        if (m.left == 0) begin
          nx.phase = 2;
          nx.data  = alu_fn(m.a, m.b, m.sel);
        end else begin
          nx.left = m.left - 1;
        end
      end else if (m.phase == 2 && rsp_ready) begin
        nx.phase = 0;
      end
      m_next = nx;
    end
  end

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [SW-1:0] s);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_sel[i*SW +: SW] = s;
  endtask

  task automatic rand_op(input int i);
    set_op(i, DW'($urandom), DW'($urandom), SW'($urandom_range(0, 15)));
  endtask

  task automatic reset_pulse();
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
  endtask

  initial begin
    int grants[5];
    int exp_order[5];
    int ng, k, l0, l1, l3;
    logic [N-1:0] got;

`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif

    // Reset held with every requester valid
    reset = 1'b0; rsp_ready = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < N; i++) rand_op(i);
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 4'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_sel", alu_sel, 4'h0);
    @(posedge clock); #1 reset = 1'b1; req_valid = 4'h0;

    // Single ADD from requester 2
    @(posedge clock); #1 set_op(2, 8'h05, 8'h03, 4'h0); req_valid = 4'b0100;
    @(negedge clock); check("single_ready", req_ready, 4'b0100);
    @(posedge clock); #1 req_valid = 4'h0;
    @(negedge clock); check("single_rv_t0", rsp_valid, 1'b0);
    @(negedge clock); check("single_rv_t1", rsp_valid, 1'b0);
    @(negedge clock);
    check("single_rv_t2", rsp_valid, 1'b1);
    check("single_id", rsp_id, 2'd2);
    check("single_data", rsp_data, 8'h08);
    check("model_data", m.data, 8'h08);
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(posedge clock); #1 rsp_ready = 1'b0;

    // Grant order with all requesters continuously valid
    reset_pulse();
    @(posedge clock); #1
    for (int i = 0; i < N; i++) set_op(i, DW'(8'h10 * (i + 1)), DW'(i), 4'h0);
    req_valid = 4'hF; rsp_ready = 1'b1;
    ng = 0; k = 0;
    while (ng < 5 && k < 60) begin
      @(negedge clock); k++;
      for (int i = 0; i < N; i++) if (req_ready[i]) begin grants[ng] = i; ng++; end
    end
    check("rr_count", ng, 5);
    for (int i = 0; i < 5; i++) if (i < ng) check("rr_order", grants[i], exp_order[i]);

    // Backpressure on the response
    @(posedge clock); #1 req_valid = 4'h0;
    k = 0;
    while (busy && k < 20) begin @(negedge clock); k++; end
    check("bp_drained", busy, 1'b0);
    @(posedge clock); #1 rsp_ready = 1'b0; set_op(1, 8'h10, 8'h20, 4'h3); req_valid = 4'b0010;
    @(negedge clock); check("bp_grant", req_ready, 4'b0010);
    @(posedge clock); #1 req_valid = 4'hF;
    k = 0;
    while (!rsp_valid && k < 10) begin @(negedge clock); k++; end
    check("bp_rsp_seen", rsp_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("bp_hold_valid", rsp_valid, 1'b1);
      check("bp_hold_data", rsp_data, 8'h30);
      check("bp_hold_id", rsp_id, 2'd1);
      check("bp_hold_ready", req_ready, 4'h0);
      check("bp_hold_busy", busy, 1'b1);
    end
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(negedge clock); check("bp_pre_hs", rsp_valid, 1'b1);
    @(negedge clock); check("bp_release", rsp_valid, 1'b0);
    @(posedge clock); #1 req_valid = 4'h0;

    // Reset while an operation waits on the ALU
    reset_pulse();
    @(posedge clock); #1 set_op(3, 8'h77, 8'h11, 4'h2); req_valid = 4'b1000; rsp_ready = 1'b1;
    @(negedge clock); check("mid_grant", req_ready, 4'b1000);
    @(posedge clock); #1 req_valid = 4'h0;
    @(negedge clock); check("mid_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1 check("mid_busy_rst", busy, 1'b0);
    check("mid_rv_rst", rsp_valid, 1'b0);
    @(posedge clock); #1 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin @(negedge clock); check("mid_no_rsp", rsp_valid, 1'b0); end
    @(posedge clock); #1 req_valid = 4'hF;
    @(negedge clock); check("mid_next_grant", req_ready, 4'b0001);

    // Randomised traffic, occasional one-cycle resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock); got = req_ready;
      @(posedge clock); #1
      for (int i = 0; i < N; i++) begin
        if (got[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          rand_op(i);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) != 0);
    end
    @(posedge clock); #1 reset = 1'b1; req_valid = 4'h0;

    // Latency sweep across the three ALU depths
    reset_pulse();
    @(posedge clock); #1 rsp_ready = 1'b0; set_op(0, 8'h21, 8'h0F, 4'h1); req_valid = 4'b0001;
    @(negedge clock);
    check("lat_grant0", req_ready0, 4'b0001);
    check("lat_grant3", req_ready3, 4'b0001);
    @(posedge clock); #1 req_valid = 4'h0;
    l0 = -1; l1 = -1; l3 = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (rsp_valid0 && l0 < 0) l0 = c;
      if (rsp_valid && l1 < 0) l1 = c;
      if (rsp_valid3 && l3 < 0) l3 = c;
    end
    check("lat0_cycles", l0, 1);
    check("lat1_cycles", l1, 2);
    check("lat3_cycles", l3, 4);
    check("lat0_data", rsp_data0, 8'h12);
    check("lat3_data", rsp_data3, 8'h12);
    check("lat3_id", rsp_id3, 2'd0);
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("lat0_released", rsp_valid0, 1'b0);
    check("lat3_released", rsp_valid3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
